timestamp_event_assembler: RTL
==============================

# timestamp_event_assembler

Downstream consumer of the timestamp divider's readout FIFO. It pops 32-bit words and checks the identifier and word order. It reassembles each three-word record into one 64-bit timestamp plus an 8-bit pulse length, and presents the result on a valid/ready event port to the histogram/TDC-correlation logic. Malformed records are dropped and counted; the assembler resynchronises on the next word-0.

## Interface
- IDENTIFIER, 4'b0001, expected value of FIFO_DATA[31:28]; must equal the upstream divider's IDENTIFIER
- BUS_CLK  in  1  single clock for all logic; the upstream FIFO read side is in this domain
- BUS_RST_N  in  1  reset, synchronous, active-low
- FIFO_EMPTY  in  1  upstream FIFO empty
- FIFO_DATA  in  32  first-word-fall-through data, valid while FIFO_EMPTY=0
- FIFO_READ  out  1  pop strobe, combinational; consumes the current word at the clock edge
- EVT_VALID  out  1  assembled event available
- EVT_READY  in  1  consumer accepts the event
- EVT_TIMESTAMP  out  64  assembled timestamp
- EVT_TOT  out  8  pulse length field from word 2
- EVT_DELTA  out  32  distance to previous accepted event (only with TS_DELTA_EN)
- CLEAR  in  1  synchronous clear of counters and delta history
- EVT_COUNT  out  32  accepted events, saturating
- ERR_COUNT  out  16  dropped/out-of-order words, saturating

## Operation
- Word format: [31:28] identifier, [27:24] index, [23:0] payload.
  - idx0 payload = TS[23:0]
  - idx1 payload = TS[47:24]
  - idx2 payload = {TOT[7:0], TS[63:48]}
- FSM states: WAIT0, WAIT1, WAIT2, HOLD. Reset state is WAIT0.
- FIFO_READ = (state ∈ {WAIT0, WAIT1, WAIT2}) & ~FIFO_EMPTY & BUS_RST_N. No pops in HOLD; this is the backpressure path.
- On a popped word in state WAITk:
  - Identifier mismatch: drop the word, ERR_COUNT+1, go to WAIT0.
  - Index = k: capture the payload, go to the next state. After WAIT2 the next state is HOLD.
  - Index = 0 while in WAIT1/WAIT2: resync. ERR_COUNT+1, capture the word as word 0, go to WAIT1.
  - Any other index: drop the word, ERR_COUNT+1, go to WAIT0.
- HOLD:
  - EVT_VALID=1 and outputs are stable.
  - On EVT_VALID & EVT_READY: EVT_COUNT+1, update the delta history, go to WAIT0.
- Counters saturate: EVT_COUNT at 32'hFFFF_FFFF, ERR_COUNT at 16'hFFFF.
- CLEAR:
  - Zeroes both counters and marks the delta history empty.
  - Does not affect the FSM or a pending event.
  - If CLEAR and an increment occur in the same cycle, CLEAR wins.

## Timing
- Reset values: EVT_VALID=0, EVT_TIMESTAMP=0, EVT_TOT=0, EVT_DELTA=0, EVT_COUNT=0, ERR_COUNT=0, FIFO_READ=0, state=WAIT0.
- Reset mid-record discards the partial record without counting an error. Reset in HOLD drops the pending event.
- Latency: word 2 popped at edge N → EVT_VALID=1 from cycle N+1.
- Handshake at edge M → EVT_VALID=0 from M+1. The earliest next pop is in cycle M+1.
- Peak throughput is one event per 4 cycles with FIFO never empty and EVT_READY held high.
- EVT_READY may be high before EVT_VALID; this has no effect outside HOLD.
- FIFO_EMPTY rising between words stalls in the current WAITk indefinitely. There is no timeout.

## Configuration
- TS_DELTA_EN defined:
  - EVT_DELTA = (TS − TS_prev) mod 2^64, saturated to 32'hFFFF_FFFF when ≥ 2^32. TS_prev is the timestamp of the last accepted event.
  - The first event after reset or CLEAR gives 0.
  - EVT_DELTA is registered together with EVT_TIMESTAMP and valid in HOLD.
- TS_DELTA_EN undefined: the EVT_DELTA port is absent, and there is no history register or subtractor.

## Test plan
- Words 0x1000_0ABC, 0x1100_0DEF, 0x12AA_1234, EVT_READY=1 → EVT_TIMESTAMP=0x1234_000DEF_000ABC, EVT_TOT=0xAA, EVT_VALID high exactly 1 cycle, EVT_COUNT=1.
- Two back-to-back records in the FIFO, EVT_READY=0 for 10 cycles after the first becomes valid → exactly 3 pops, EVT_VALID held with stable data, remaining 3 words popped only after the handshake.
- idx0, idx0, idx1, idx2 → ERR_COUNT=1, one event built from the second idx0.
- Identifier 0x2 record → all 3 words dropped, ERR_COUNT=3, no EVT_VALID. Then a valid record → event OK.
- TS_DELTA_EN with events TS=100, TS=350, then TS=100+2^33 → EVT_DELTA=0, 250, 0xFFFF_FFFF. CLEAR, then next event → 0.
- BUS_RST_N low for 1 cycle after word 1 is popped → outputs at reset values. Then idx2 arrives → ERR_COUNT=1 and no event.

Source files
------------

// File: rtl/timestamp_event_assembler.sv
// Reassembles three-word timestamp records popped from a first-word-fall-through FIFO into
// 64-bit timestamp events on a valid/ready port. Optional macro TS_DELTA_EN adds EVT_DELTA.
module timestamp_event_assembler #(
  parameter logic [3:0] IDENTIFIER = 4'b0001
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic [63:0] EVT_TIMESTAMP,
  output logic [7:0]  EVT_TOT,
`ifdef TS_DELTA_EN
  output logic [31:0] EVT_DELTA,
`endif
  input  logic        CLEAR,
  output logic [31:0] EVT_COUNT,
  output logic [15:0] ERR_COUNT
);

  // state | meaning
  // WAIT0 | waiting for word 0 (TS[23:0])
  // WAIT1 | waiting for word 1 (TS[47:24])
  // WAIT2 | waiting for word 2 ({TOT, TS[63:48]})
  // HOLD  | event presented, FIFO pops stalled until handshake
  typedef enum logic [1:0] {
    WAIT0 = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  logic [23:0] ts_lo;
  logic [23:0] ts_mid;

  logic [3:0]  word_id;
  logic [3:0]  word_idx;
  logic [23:0] word_payload;
  logic [3:0]  want_idx;
  logic        id_ok;
  logic        idx_ok;
  logic        resync;
  logic        capture;
  logic        handshake;
  logic        err_inc;
  logic [63:0] new_ts;

  always_comb begin
    word_id      = FIFO_DATA[31:28];
    word_idx     = FIFO_DATA[27:24];
    word_payload = FIFO_DATA[23:0];
    want_idx     = 4'd0;
    case (state)
      WAIT1:   want_idx = 4'd1;
      WAIT2:   want_idx = 4'd2;
      default: want_idx = 4'd0;
    endcase
    FIFO_READ = (state != HOLD) & ~FIFO_EMPTY & BUS_RST_N;
    id_ok     = (word_id == IDENTIFIER);
    idx_ok    = id_ok & (word_idx == want_idx);
    // a fresh word 0 mid-record restarts assembly instead of waiting for another one
    resync    = id_ok & (word_idx == 4'd0) & ~idx_ok;
    capture   = FIFO_READ & (state == WAIT2) & idx_ok;
    handshake = EVT_VALID & EVT_READY;
    err_inc   = FIFO_READ & ~idx_ok;
    new_ts    = {word_payload[15:0], ts_mid, ts_lo};
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state         <= WAIT0;
      ts_lo         <= '0;
      ts_mid        <= '0;
      EVT_VALID     <= 1'b0;
      EVT_TIMESTAMP <= '0;
      EVT_TOT       <= '0;
    end else begin
      case (state)
        WAIT0, WAIT1, WAIT2: begin
          if (FIFO_READ) begin
            if (idx_ok) begin
              case (state)
                WAIT0: begin
                  ts_lo <= word_payload;
                  state <= WAIT1;
                end
                WAIT1: begin
                  ts_mid <= word_payload;
                  state  <= WAIT2;
                end
                default: begin
                  EVT_TIMESTAMP <= new_ts;
                  EVT_TOT       <= word_payload[23:16];
                  EVT_VALID     <= 1'b1;
                  state         <= HOLD;
                end
              endcase
            end else if (resync) begin
              ts_lo <= word_payload;
              state <= WAIT1;
            end else begin
              state <= WAIT0;
            end
          end
        end
        HOLD: begin
          if (EVT_READY) begin
            EVT_VALID <= 1'b0;
            state     <= WAIT0;
          end
        end
        default: state <= WAIT0;
      endcase
    end
  end

  // CLEAR takes priority over any increment in the same cycle
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      EVT_COUNT <= '0;
      ERR_COUNT <= '0;
    end else if (CLEAR) begin
      EVT_COUNT <= '0;
      ERR_COUNT <= '0;
    end else begin
      if (handshake && (EVT_COUNT != 32'hFFFF_FFFF))
        EVT_COUNT <= EVT_COUNT + 32'd1;
      if (err_inc && (ERR_COUNT != 16'hFFFF))
        ERR_COUNT <= ERR_COUNT + 16'd1;
    end
  end

`ifdef TS_DELTA_EN
  logic [63:0] ts_prev;
  logic        hist_valid;
  logic [63:0] delta_raw;

  always_comb begin
    delta_raw = new_ts - ts_prev;
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      ts_prev    <= '0;
      hist_valid <= 1'b0;
      EVT_DELTA  <= '0;
    end else begin
      if (capture) begin
        if (!hist_valid || CLEAR)
          EVT_DELTA <= '0;
        else if (delta_raw[63:32] != 32'd0)
          EVT_DELTA <= 32'hFFFF_FFFF;
        else
          EVT_DELTA <= delta_raw[31:0];
      end
      if (CLEAR) begin
        hist_valid <= 1'b0;
      end else if (handshake) begin
        ts_prev    <= EVT_TIMESTAMP;
        hist_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
